// File: rtl/rr_mux_pkg.sv
// Shared lane count, select width and output-register state type for the 4-to-1 round-robin mux.
// Used by both builds (RR_MUX_FIXED_PRIO_EN defined or undefined).
package rr_mux_pkg;

    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // The pointer naturally wraps 3 -> 0 through the two-bit addition.
    function automatic logic [SEL_W-1:0] nextLane(input logic [SEL_W-1:0] lane);
        return lane + SEL_W'(1);
    endfunction

endpackage

// File: rtl/rr_mux_4_to_1_arbiter.sv
// Grant logic for four lanes: rotating priority from ptr, or fixed lane-0-first priority
// when RR_MUX_FIXED_PRIO_EN is defined (ptr is then ignored).
module rr_arbiter_4
    import rr_mux_pkg::*;
(
    input  logic [NUM_LANES-1:0] req,
    input  logic [SEL_W-1:0]     ptr,
    input  logic                 en,
    output logic [NUM_LANES-1:0] gnt,
    output logic [SEL_W-1:0]     gnt_idx
);

`ifdef RR_MUX_FIXED_PRIO_EN

    logic unusedPtr;
    assign unusedPtr = ^ptr;

    // Scanning downward lets the lowest valid lane overwrite any higher one.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (en && req[k]) begin
                gnt     = '0;
                gnt[k]  = 1'b1;
                gnt_idx = SEL_W'(k);
            end
        end
    end

`else

    logic             found;
    logic [SEL_W-1:0] idx;

    // Visit ptr, ptr+1, ... modulo 4 and keep the first requesting lane.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = ptr;
        for (int k = 0; k < NUM_LANES; k++) begin
            idx = ptr + SEL_W'(k);
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

`endif

endmodule

// File: rtl/rr_mux_4_to_1.sv
// Four-lane valid/ready mux with a single registered output stage and round-robin arbitration;
// defining RR_MUX_FIXED_PRIO_EN swaps in fixed lane-0-first priority and drops the pointer.
module rr_mux_4_to_1
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = 8
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_LANES-1:0]       in_valid,
    input  logic [NUM_LANES*WIDTH-1:0] in_data,
    output logic [NUM_LANES-1:0]       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [SEL_W-1:0]           out_sel,
    input  logic                       out_ready
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] outData_q, outData_d;
    logic [SEL_W-1:0] outSel_q, outSel_d;

    logic                 canLoad;
    logic                 grant;
    logic [NUM_LANES-1:0] gnt;
    logic [SEL_W-1:0]     gntIdx;
    logic [SEL_W-1:0]     ptrArb;
    logic [WIDTH-1:0]     laneData [NUM_LANES];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign laneData[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Reset blocks loading so nothing is accepted while the register is being cleared.
    assign canLoad = !rst && ((state_q == EMPTY) || out_ready);

    rr_arbiter_4 u_arb (
        .req     (in_valid),
        .ptr     (ptrArb),
        .en      (canLoad),
        .gnt     (gnt),
        .gnt_idx (gntIdx)
    );

    assign grant    = |gnt;
    assign in_ready = gnt;

`ifdef RR_MUX_FIXED_PRIO_EN

    assign ptrArb = '0;

`else

    logic [SEL_W-1:0] ptr_q, ptr_d;

    assign ptr_d  = grant ? nextLane(gntIdx) : ptr_q;
    assign ptrArb = ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

    always_comb begin
        state_d   = state_q;
        outData_d = outData_q;
        outSel_d  = outSel_q;
        case (state_q)
            EMPTY: if (grant) state_d = FULL;
            FULL:  if (out_ready && !grant) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (grant) begin
            outData_d = laneData[gntIdx];
            outSel_d  = gntIdx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            outData_q <= '0;
            outSel_q  <= '0;
        end else begin
            state_q   <= state_d;
            outData_q <= outData_d;
            outSel_q  <= outSel_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = outData_q;
    assign out_sel   = outSel_q;

    // A stalled beat must not move, and accepts must be single and requested.
    assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
    assert property (@(posedge clk) disable iff (rst) (in_ready & ~in_valid) == '0);
    assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_sel)));

endmodule

// File: tb/tb_rr_mux_4_to_1.sv
// Scoreboard bench for rr_mux_4_to_1: directed vectors push expected beats, a monitor pops them.
// Expectations follow RR_MUX_FIXED_PRIO_EN when the bench is built with it.
module tb_rr_mux_4_to_1;

    localparam int W = 8;
`ifdef RR_MUX_FIXED_PRIO_EN
    localparam bit FixedPrio = 1'b1;
`else
    localparam bit FixedPrio = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]   sel;
        logic [W-1:0] data;
    } beat_t;

    logic           clk;
    logic           rst;
    logic [3:0]     in_valid;
    logic [4*W-1:0] in_data;
    logic [3:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_ready;

    beat_t expQ[$];
    int    checks = 0;
    int    passes = 0;

    rr_mux_4_to_1 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Drives one cycle, checks in_ready against the hand-computed grant and queues the beat it implies.
    task automatic applyStimulus(input logic rstV, input logic [3:0] valid, input logic [4*W-1:0] data,
                                 input logic rdy, input logic [3:0] expReady);
        beat_t b;
        @(posedge clk);
        #1;
        rst       = rstV;
        in_valid  = valid;
        in_data   = data;
        out_ready = rdy;
        @(negedge clk);
        checkOutput("in_ready", {28'd0, in_ready}, {28'd0, expReady});
        for (int i = 0; i < 4; i++) begin
            if (expReady[i]) begin
                b.sel  = 2'(i);
                b.data = data[i*W +: W];
                expQ.push_back(b);
            end
        end
    endtask

    task automatic checkRegister(input string tag, input logic expValid, input logic [1:0] expSel,
                                 input logic [W-1:0] expData);
        checkOutput({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, expValid});
        checkOutput({tag, " out_sel"},   {30'd0, out_sel},   {30'd0, expSel});
        checkOutput({tag, " out_data"},  {24'd0, out_data},  {24'd0, expData});
    endtask

    // Monitor: every accepted output beat must match the oldest expected beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_beat: got sel %0h data %0h, expected no beat", out_sel, out_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("beat out_sel",  {30'd0, out_sel},  {30'd0, e.sel});
                    checkOutput("beat out_data", {24'd0, out_data}, {24'd0, e.data});
                end
            end
        end
    end

    initial begin
        logic [4*W-1:0] d0, d1, d2, d3, d4, d5;
        d0 = {8'h00, 8'h00, 8'h00, 8'hA5};
        d1 = {8'h13, 8'h12, 8'h11, 8'h10};
        d2 = {8'h77, 8'h3C, 8'h55, 8'h44};
        d3 = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        d4 = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
        d5 = {8'hF3, 8'hF2, 8'hF1, 8'hF0};
        rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;

        // Reset state, and no accepts while reset is held even with lanes valid.
        applyStimulus(1'b1, 4'b0000, d0, 1'b0, 4'b0000);
        applyStimulus(1'b1, 4'b0000, d0, 1'b0, 4'b0000);
        checkRegister("reset", 1'b0, 2'b00, 8'h00);
        applyStimulus(1'b1, 4'b1111, d0, 1'b1, 4'b0000);

        // Single beat on lane 0 appears one cycle later.
        applyStimulus(1'b0, 4'b0001, d0, 1'b1, 4'b0001);
        applyStimulus(1'b0, 4'b0000, d0, 1'b1, 4'b0000);
        checkRegister("single", 1'b1, 2'b00, 8'hA5);
        applyStimulus(1'b1, 4'b0000, d0, 1'b1, 4'b0000);

        // All lanes valid: rotate 0,1,2,3,0 with no bubbles.
        applyStimulus(1'b0, 4'b1111, d1, 1'b1, 4'b0001);
        applyStimulus(1'b0, 4'b1111, d1, 1'b1, FixedPrio ? 4'b0001 : 4'b0010);
        checkOutput("stream out_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus(1'b0, 4'b1111, d1, 1'b1, FixedPrio ? 4'b0001 : 4'b0100);
        checkOutput("stream out_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus(1'b0, 4'b1111, d1, 1'b1, FixedPrio ? 4'b0001 : 4'b1000);
        checkOutput("stream out_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus(1'b0, 4'b1111, d1, 1'b1, 4'b0001);
        checkOutput("stream out_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus(1'b0, 4'b0000, d1, 1'b1, 4'b0000);
        checkOutput("stream out_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus(1'b0, 4'b0000, d1, 1'b1, 4'b0000);
        checkOutput("drained out_valid", {31'd0, out_valid}, 32'd0);

        // Stall: lane 2 beat 3C held for three cycles while others wait.
        applyStimulus(1'b0, 4'b0100, d2, 1'b1, 4'b0100);
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b0, 4'b1111, d2, 1'b0, 4'b0000);
            checkRegister("stall", 1'b1, 2'b10, 8'h3C);
        end
        applyStimulus(1'b0, 4'b0000, d2, 1'b1, 4'b0000);
        checkRegister("release", 1'b1, 2'b10, 8'h3C);

        // Pointer wrap: ptr=2 with 1001 grants lane 3, then lane 0.
        applyStimulus(1'b0, 4'b0010, d3, 1'b1, 4'b0010);
        applyStimulus(1'b0, 4'b1001, d3, 1'b1, FixedPrio ? 4'b0001 : 4'b1000);
        applyStimulus(1'b0, 4'b1001, d3, 1'b1, 4'b0001);
        applyStimulus(1'b0, 4'b1001, d3, 1'b1, FixedPrio ? 4'b0001 : 4'b1000);
        applyStimulus(1'b0, 4'b0000, d3, 1'b1, 4'b0000);

        // Reset while FULL discards the held beat and restarts the pointer at 0.
        applyStimulus(1'b0, 4'b1111, d4, 1'b0, 4'b0001);
        applyStimulus(1'b0, 4'b1111, d4, 1'b0, 4'b0000);
        checkRegister("prereset", 1'b1, 2'b00, 8'hE0);
        applyStimulus(1'b1, 4'b1111, d4, 1'b1, 4'b0000);
        expQ.delete();
        applyStimulus(1'b0, 4'b1011, d4, 1'b1, 4'b0001);
        checkOutput("postreset out_valid", {31'd0, out_valid}, 32'd0);
        applyStimulus(1'b0, 4'b0000, d4, 1'b1, 4'b0000);
        checkRegister("postreset", 1'b1, 2'b00, 8'hE0);

        // Lanes 1 and 2 held: alternate, or lane 1 only under fixed priority.
        applyStimulus(1'b0, 4'b0110, d5, 1'b1, 4'b0010);
        applyStimulus(1'b0, 4'b0110, d5, 1'b1, FixedPrio ? 4'b0010 : 4'b0100);
        applyStimulus(1'b0, 4'b0110, d5, 1'b1, 4'b0010);
        applyStimulus(1'b0, 4'b0110, d5, 1'b1, FixedPrio ? 4'b0010 : 4'b0100);
        applyStimulus(1'b0, 4'b0000, d5, 1'b1, 4'b0000);
        applyStimulus(1'b0, 4'b0000, d5, 1'b1, 4'b0000);

        checkOutput("pending beats", expQ.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
